// File: rtl/gnr_node_lut.sv
// gnr_node_lut: Boolean-network gene node with a runtime-loaded truth table and slow/fast trajectory copies.
// Optional knockout override is enabled by defining GNR_NODE_KNOCKOUT_EN (adds ko_en/ko_val ports).
module gnr_node_lut #(
   parameter int NUM_IN   = 4,
   parameter int SLOW_DIV = 2,
   parameter int CNT_W    = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   reset_nos,
   input  logic                   init_state,
   input  logic                   start_s0,
   input  logic                   start_s1,
   input  logic [NUM_IN-1:0]      reg_s0,
   input  logic [NUM_IN-1:0]      reg_s1,
   input  logic                   cfg_we,
   input  logic [2**NUM_IN-1:0]   cfg_lut,
`ifdef GNR_NODE_KNOCKOUT_EN
   input  logic                   ko_en,
   input  logic                   ko_val,
`endif
   output logic                   s0,
   output logic                   s1,
   output logic                   states_eq,
   output logic [CNT_W-1:0]       flip_cnt
);
   localparam int DEPTH = 2**NUM_IN;
   localparam int PW    = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
   localparam logic [PW-1:0] PH_LAST = PW'(SLOW_DIV-1);

   logic [DEPTH-1:0] lut_q, lut_d;
   logic             s0_q, s0_d, s1_q, s1_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             nxt0, nxt1, init_v, wrap;

   // Knockout substitutes a forced value for both the LUT output and the re-init value.
`ifdef GNR_NODE_KNOCKOUT_EN
   assign nxt0   = ko_en ? ko_val : lut_q[reg_s0];
   assign nxt1   = ko_en ? ko_val : lut_q[reg_s1];
   assign init_v = ko_en ? ko_val : init_state;
`else
   assign nxt0   = lut_q[reg_s0];
   assign nxt1   = lut_q[reg_s1];
   assign init_v = init_state;
`endif

   assign wrap = phase_q == PH_LAST;

   always_comb begin
      lut_d   = cfg_we ? cfg_lut : lut_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      if (reset_nos) begin
         s0_d    = init_v;
         s1_d    = init_v;
         phase_d = PH_LAST;
         cnt_d   = '0;
      end else begin
         if (start_s0) begin
            s0_d    = wrap ? nxt0 : s0_q;
            phase_d = wrap ? '0 : phase_q + 1'b1;
         end
         if (start_s1) begin
            s1_d  = nxt1;
            cnt_d = (nxt1 != s1_q && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lut_q   <= '0;
         s0_q    <= 1'b0;
         s1_q    <= 1'b0;
         phase_q <= PH_LAST;
         cnt_q   <= '0;
      end else begin
         lut_q   <= lut_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
      end
   end

   assign s0        = s0_q;
   assign s1        = s1_q;
   assign states_eq = s0_q == s1_q;
   assign flip_cnt  = cnt_q;
endmodule

// File: tb/tb_gnr_node_lut.sv
// tb_gnr_node_lut: directed vector bench for gnr_node_lut (two parameterisations).
module tb_gnr_node_lut;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic ko_en, ko_val;
   logic a_rn, a_init, a_st0, a_st1, a_we;
   logic [1:0] a_r0, a_r1;
   logic [3:0] a_lut;
   logic a_s0, a_s1, a_eq;
   logic [1:0] a_cnt;
   logic b_rn, b_init, b_st0, b_st1, b_we;
   logic [3:0] b_r0, b_r1;
   logic [15:0] b_lut;
   logic b_s0, b_s1, b_eq;
   logic [7:0] b_cnt;

   int errs = 0;
   int checks = 0;

   gnr_node_lut #(.NUM_IN(2), .SLOW_DIV(2), .CNT_W(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .reset_nos(a_rn), .init_state(a_init),
      .start_s0(a_st0), .start_s1(a_st1), .reg_s0(a_r0), .reg_s1(a_r1),
      .cfg_we(a_we), .cfg_lut(a_lut),
`ifdef GNR_NODE_KNOCKOUT_EN
      .ko_en(ko_en), .ko_val(ko_val),
`endif
      .s0(a_s0), .s1(a_s1), .states_eq(a_eq), .flip_cnt(a_cnt));

   gnr_node_lut #(.NUM_IN(4), .SLOW_DIV(3), .CNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .reset_nos(b_rn), .init_state(b_init),
      .start_s0(b_st0), .start_s1(b_st1), .reg_s0(b_r0), .reg_s1(b_r1),
      .cfg_we(b_we), .cfg_lut(b_lut),
`ifdef GNR_NODE_KNOCKOUT_EN
      .ko_en(ko_en), .ko_val(ko_val),
`endif
      .s0(b_s0), .s1(b_s1), .states_eq(b_eq), .flip_cnt(b_cnt));

   typedef struct {
      logic we; logic [3:0] lut; logic rn, init, st0, st1;
      logic [1:0] r0, r1; logic e0, e1; logic [1:0] ec;
   } vec_t;
   vec_t v[18];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_idle();
      a_rn = 0; a_init = 0; a_st0 = 0; a_st1 = 0; a_we = 0; a_r0 = 0; a_r1 = 0; a_lut = 0;
   endtask

   logic [3:0] t3_r[6];
   logic       t3_e[6];

   initial begin
      // fields: we, lut, rn, init, st0, st1, r0, r1 -> s0, s1, flip_cnt
      v[0]  = '{1, 4'b0110, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0};
      v[1]  = '{0, 4'b0000, 0, 0, 0, 1, 2'd0, 2'd1, 0, 1, 2'd1};
      v[2]  = '{0, 4'b0000, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0};
      v[3]  = '{0, 4'b0000, 0, 0, 1, 0, 2'd1, 2'd0, 1, 0, 2'd0};
      v[4]  = '{0, 4'b0000, 0, 0, 1, 0, 2'd0, 2'd0, 1, 0, 2'd0};
      v[5]  = '{0, 4'b0000, 0, 0, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0};
      v[6]  = '{0, 4'b0000, 0, 0, 1, 0, 2'd1, 2'd0, 0, 0, 2'd0};
      v[7]  = '{1, 4'b1111, 0, 0, 0, 1, 2'd0, 2'd0, 0, 0, 2'd0};
      v[8]  = '{0, 4'b0000, 0, 0, 0, 1, 2'd0, 2'd0, 0, 1, 2'd1};
      v[9]  = '{1, 4'b0110, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0};
      v[10] = '{0, 4'b0000, 0, 0, 0, 1, 2'd0, 2'd1, 0, 1, 2'd1};
      v[11] = '{0, 4'b0000, 0, 0, 0, 1, 2'd0, 2'd0, 0, 0, 2'd2};
      v[12] = '{0, 4'b0000, 0, 0, 0, 1, 2'd0, 2'd2, 0, 1, 2'd3};
      v[13] = '{0, 4'b0000, 0, 0, 0, 1, 2'd0, 2'd3, 0, 0, 2'd3};
      v[14] = '{0, 4'b0000, 0, 0, 0, 1, 2'd0, 2'd1, 0, 1, 2'd3};
      v[15] = '{0, 4'b0000, 1, 1, 1, 1, 2'd1, 2'd0, 1, 1, 2'd0};
      v[16] = '{0, 4'b0000, 0, 0, 1, 1, 2'd0, 2'd0, 0, 0, 2'd1};
      v[17] = '{0, 4'b0000, 0, 0, 1, 1, 2'd1, 2'd0, 0, 0, 2'd1};
      t3_r = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1};
      t3_e = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

      rst_n = 0; ko_en = 0; ko_val = 0;
      a_idle();
      b_rn = 0; b_init = 0; b_st0 = 0; b_st1 = 0; b_we = 0; b_r0 = 0; b_r1 = 0; b_lut = 0;
      tick(); tick();
      chk("rst_a_s0", 16'(a_s0), 16'd0);
      chk("rst_a_s1", 16'(a_s1), 16'd0);
      chk("rst_a_eq", 16'(a_eq), 16'd1);
      chk("rst_a_cnt", 16'(a_cnt), 16'd0);
      chk("rst_b_cnt", 16'(b_cnt), 16'd0);
      rst_n = 1;

      for (int i = 0; i < 18; i++) begin
         a_we = v[i].we; a_lut = v[i].lut; a_rn = v[i].rn; a_init = v[i].init;
         a_st0 = v[i].st0; a_st1 = v[i].st1; a_r0 = v[i].r0; a_r1 = v[i].r1;
         tick();
         chk($sformatf("vec%0d_s0", i), 16'(a_s0), 16'(v[i].e0));
         chk($sformatf("vec%0d_s1", i), 16'(a_s1), 16'(v[i].e1));
         chk($sformatf("vec%0d_eq", i), 16'(a_eq), 16'(v[i].e0 == v[i].e1));
         chk($sformatf("vec%0d_cnt", i), 16'(a_cnt), 16'(v[i].ec));
      end
      a_idle();

      // SLOW_DIV=3: held strobe updates s0 only after strobes 1 and 4
      b_we = 1; b_lut = 16'h0002; b_rn = 1; b_init = 0;
      tick();
      b_we = 0; b_rn = 0;
      chk("t3_init", 16'(b_s0), 16'd0);
      b_st0 = 1;
      for (int k = 0; k < 6; k++) begin
         b_r0 = t3_r[k];
         tick();
         chk($sformatf("t3_strobe%0d", k + 1), 16'(b_s0), 16'(t3_e[k]));
      end
      b_st0 = 0;
      chk("t3_s1_untouched", 16'(b_s1), 16'd0);

      // async reset mid-burst
      a_rn = 1; a_init = 1;
      tick();
      a_rn = 0; a_st1 = 1; a_r1 = 2'd0;
      tick();
      chk("t6_pre_s1", 16'(a_s1), 16'd0);
      chk("t6_pre_cnt", 16'(a_cnt), 16'd1);
      #2 rst_n = 0;
      #1;
      chk("t6_async_s0", 16'(a_s0), 16'd0);
      chk("t6_async_s1", 16'(a_s1), 16'd0);
      chk("t6_async_cnt", 16'(a_cnt), 16'd0);
      chk("t6_async_b_s0", 16'(b_s0), 16'd0);
      a_idle();
      tick();
      rst_n = 1;
      a_rn = 1; a_init = 1;
      tick();
      a_rn = 0; a_st1 = 1; a_r1 = 2'd1;
      tick();
      a_st1 = 0;
      chk("t6_lut_cleared_s1", 16'(a_s1), 16'd0);
      chk("t6_lut_cleared_cnt", 16'(a_cnt), 16'd1);

`ifdef GNR_NODE_KNOCKOUT_EN
      ko_en = 1; ko_val = 1;
      a_rn = 1; a_init = 0;
      tick();
      chk("ko_reset_s0", 16'(a_s0), 16'd1);
      a_rn = 0; a_st0 = 1; a_st1 = 1;
      tick();
      a_idle();
      chk("ko_step_s0", 16'(a_s0), 16'd1);
      chk("ko_step_s1", 16'(a_s1), 16'd1);
      ko_en = 0; ko_val = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
